// File: rtl/zion_processor_component_lib_pkg.sv
// Shared types for the forwarding hazard controller: register index width,
// scoreboard entry layout and the hazard-reason encoding.
package zion_processor_component_lib_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int SB_CNT_W       = 3;

  typedef struct packed {
    logic                pend;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  typedef enum logic [1:0] {
    HZ_NONE    = 2'd0,
    HZ_RAW_RS1 = 2'd1,
    HZ_RAW_RS2 = 2'd2,
    HZ_WAW     = 2'd3
  } hazard_e;

endpackage

// File: rtl/zion_processor_component_lib_sb_entry.sv
// One scoreboard entry: pending flag plus countdown to forwarding-bus arrival.
// Priority: flush, then load (reload beats writeback and decrement), then clear/decrement.
module zion_processor_component_lib_sb_entry
  import zion_processor_component_lib_pkg::*;
(
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iFlush,
  input  logic                iLoad,
  input  logic [SB_CNT_W-1:0] iLoadCnt,
  input  logic                iClr,
  output sb_entry_t           oEntry
);

  sb_entry_t r_entry;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_entry <= '0;
    end else if (iFlush) begin
      r_entry <= '0;
    end else if (iLoad) begin
      r_entry.pend <= 1'b1;
      r_entry.cnt  <= iLoadCnt;
    end else begin
      if (iClr) begin
        r_entry.pend <= 1'b0;
      end
      if (r_entry.pend && (r_entry.cnt != '0)) begin
        r_entry.cnt <= r_entry.cnt - 1'b1;
      end
    end
  end

  assign oEntry = r_entry;

endmodule

// File: rtl/zion_processor_component_lib_fwd_hazard_ctrl.sv
// Scoreboard hazard controller gating issue until operands are readable or forwardable.
// Optional stall counter: define ZION_FWD_HAZARD_CTRL_STALL_CNT_EN.
module zion_processor_component_lib_fwd_hazard_ctrl
  import zion_processor_component_lib_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int LAT_WIDTH = SB_CNT_W
`ifdef ZION_FWD_HAZARD_CTRL_STALL_CNT_EN
  , parameter int STALL_CNT_WIDTH = 32
`endif
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iIssVld,
  output logic                      oIssRdy,
  input  logic [REG_ADDR_WIDTH-1:0] iRs1,
  input  logic [REG_ADDR_WIDTH-1:0] iRs2,
  input  logic [REG_ADDR_WIDTH-1:0] iRd,
  input  logic                      iRdWr,
  input  logic [LAT_WIDTH-1:0]      iLat,
  input  logic                      iWbVld,
  input  logic [REG_ADDR_WIDTH-1:0] iWbRd,
  input  logic                      iFlush,
  output logic [REG_NUM-1:0]        oPendMap
`ifdef ZION_FWD_HAZARD_CTRL_STALL_CNT_EN
  , output logic [STALL_CNT_WIDTH-1:0] oStallCnt
`endif
);

  logic [REG_NUM-1:0]   w_pend;
  logic [LAT_WIDTH-1:0] w_cnt [REG_NUM];
  logic                 w_acc;
  hazard_e              w_hz;

  // Register 0 is hard-wired zero and never tracked.
  assign w_pend[0] = 1'b0;
  assign w_cnt[0]  = '0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_sb
    sb_entry_t w_entry;

    zion_processor_component_lib_sb_entry u_entry (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iFlush   (iFlush),
      .iLoad    (w_acc & iRdWr & (iRd == REG_ADDR_WIDTH'(r))),
      .iLoadCnt (iLat),
      .iClr     (iWbVld & (iWbRd == REG_ADDR_WIDTH'(r))),
      .oEntry   (w_entry)
    );

    assign w_pend[r] = w_entry.pend;
    assign w_cnt[r]  = w_entry.cnt;
  end

  // A pending entry with cnt==0 is already on the forwarding bus, so only a
  // nonzero countdown blocks a reader; WAW blocks when the older write lands later.
  always_comb begin
    w_hz = HZ_NONE;
    if ((iRs1 != '0) && w_pend[iRs1] && (w_cnt[iRs1] != '0)) begin
      w_hz = HZ_RAW_RS1;
    end else if ((iRs2 != '0) && w_pend[iRs2] && (w_cnt[iRs2] != '0)) begin
      w_hz = HZ_RAW_RS2;
    end else if (iRdWr && (iRd != '0) && w_pend[iRd] && (w_cnt[iRd] > iLat)) begin
      w_hz = HZ_WAW;
    end
  end

  assign oIssRdy  = ~iFlush & (w_hz == HZ_NONE);
  assign w_acc    = iIssVld & oIssRdy;
  assign oPendMap = w_pend;

`ifdef ZION_FWD_HAZARD_CTRL_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_stall_cnt <= '0;
    end else if (iIssVld && !oIssRdy && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign oStallCnt = r_stall_cnt;
`endif

endmodule
